// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle word load/store responder for the MIPS
// load/store path. Byte-addressed little-endian storage, programmable wait
// states, misaligned or out-of-range accesses flagged instead of performed.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once raised, rsp_valid stays high with rsp_rdata/rsp_err stable
// until that transfer. req_ready depends on state only and is never high
// together with rsp_valid, so at most one request is ever outstanding.
module data_mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // Storage is deliberately outside reset: a completed store survives reset.
  logic [7:0]  mem [0:(1<<ADDR_BITS)-1];

  logic                 acc_now;
  logic                 acc_write;
  logic [31:0]          acc_addr;
  logic [31:0]          acc_wdata;
  logic                 acc_err;
  logic [ADDR_BITS-3:0] acc_word;
  logic [31:0]          rd_word;
  logic [31:0]          acc_rdata;

  // With zero wait states the access uses the request straight off the bus;
  // otherwise it uses the copy latched at acceptance.
  always_comb begin
    acc_now   = ((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                ((state == S_WAIT) && (cnt == 4'd0));
    acc_write = (state == S_IDLE) ? req_write : lat_write;
    acc_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
    acc_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
    acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_BITS] != '0);
    acc_word  = acc_addr[ADDR_BITS-1:2];
    rd_word   = {mem[{acc_word, 2'd3}], mem[{acc_word, 2'd2}],
                 mem[{acc_word, 2'd1}], mem[{acc_word, 2'd0}]};
    acc_rdata = (acc_err || acc_write) ? 32'd0 : rd_word;
  end

  // Ready only in IDLE and never while reset is held.
  always_comb begin
    req_ready = (state == S_IDLE) && rst_n;
    dbg_state = state;
  end

  // Little-endian word store; the range check guarantees no index wrap.
  always_ff @(posedge clk) begin
    if (acc_now && rst_n && acc_write && !acc_err) begin
      mem[{acc_word, 2'd0}] <= acc_wdata[7:0];
      mem[{acc_word, 2'd1}] <= acc_wdata[15:8];
      mem[{acc_word, 2'd2}] <= acc_wdata[23:16];
      mem[{acc_word, 2'd3}] <= acc_wdata[31:24];
    end
  end

  // Request/wait/response sequencing with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= acc_rdata;
              rsp_err   <= acc_err;
            end else begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= acc_rdata;
            rsp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
